// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip8_pkg
// Purpose  : Shared types and constants for the CHIP-8 core memory stage and
//            the writeback stage it feeds.
// Contents : ADDR_W    - default memory address width
//            mem_op_e  - memory-stage operation selector
//            wb_beat_t - one beat delivered to writeback
// Revision : 1.0 - initial release
// ============================================================================
package chip8_pkg;

    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        OP_PASS       = 2'd0,
        OP_STORE_REGS = 2'd1,
        OP_LOAD_REGS  = 2'd2,
        OP_BCD        = 2'd3
    } mem_op_e;

    // "reg" is a keyword, so the destination index field is called rd.
    typedef struct packed {
        logic [3:0]        rd;
        logic [7:0]        data;
        logic              we;
        logic              i_we;
        logic [ADDR_W-1:0] i_data;
        logic              last;
    } wb_beat_t;

endpackage
`default_nettype wire

// File: rtl/bin2bcd8.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd8
// Purpose  : Combinational 8-bit binary to three-digit BCD (double-dabble).
// Ports    : bin      in  8  binary value (0..255)
//            hundreds out 4  hundreds digit (0..2)
//            tens     out 4  tens digit
//            ones     out 4  ones digit
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd8 (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // Shift register: [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] bin.
    logic [19:0] w_sr;

    always_comb begin
        w_sr = {12'd0, bin};
        for (int k = 0; k < 8; k++) begin
            // Add 3 to any digit >= 5 so the following shift carries correctly.
            if (w_sr[11:8]  >= 4'd5) w_sr[11:8]  = w_sr[11:8]  + 4'd3;
            if (w_sr[15:12] >= 4'd5) w_sr[15:12] = w_sr[15:12] + 4'd3;
            if (w_sr[19:16] >= 4'd5) w_sr[19:16] = w_sr[19:16] + 4'd3;
            w_sr = w_sr << 1;
        end
        hundreds = w_sr[19:16];
        tens     = w_sr[15:12];
        ones     = w_sr[11:8];
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of the pipelined CHIP-8 core. Forwards ALU
//            results and sequences FX55 (store V0..VX), FX65 (load V0..VX)
//            and FX33 (BCD store) as one or more beats to writeback.
// Ports    : clk, rst                   clock, async active-high reset
//            in_valid/in_ready          execute handshake
//            in_op,in_x,in_i,in_vx      operation, X, current I, VX
//            in_dst,in_data,in_we       PASS destination/result/enable
//            rf_raddr/rf_rdata          register-file read (store)
//            mem_addr,mem_we,mem_wdata  memory write port
//            mem_re/mem_rdata           memory read (data one cycle later)
//            wb_valid/wb_ready          writeback handshake
//            wb_reg,wb_data,wb_we       register write beat
//            wb_i_we,wb_i_data,wb_last  I update, final-beat flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ADDR_W = chip8_pkg::ADDR_W,
    parameter int INC_I  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_x,
    input  logic [ADDR_W-1:0] in_i,
    input  logic [7:0]        in_vx,
    input  logic [3:0]        in_dst,
    input  logic [7:0]        in_data,
    input  logic              in_we,
    output logic [3:0]        rf_raddr,
    input  logic [7:0]        rf_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [3:0]        wb_reg,
    output logic [7:0]        wb_data,
    output logic              wb_we,
    output logic              wb_i_we,
    output logic [ADDR_W-1:0] wb_i_data,
    output logic              wb_last
);
    import chip8_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OUT   = 3'd1,
        S_STORE = 3'd2,
        S_LD_RD = 3'd3,
        S_LD_WB = 3'd4,
        S_BCD   = 3'd5
    } state_e;

    localparam logic c_inc_i = (INC_I != 0);

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_idx, w_idx_nxt;
    logic [3:0]        r_x;
    logic [ADDR_W-1:0] r_i;
    logic [7:0]        r_vx;
    logic              r_ld_first;    // first cycle of LD_WB: read data is live

    logic              r_wb_valid, r_wb_we, r_wb_i_we, r_wb_last;
    logic [3:0]        r_wb_reg;
    logic [7:0]        r_wb_data;
    logic [ADDR_W-1:0] r_wb_i_data;

    logic              w_beat_load, w_beat_we, w_beat_i_we, w_beat_last;
    logic [3:0]        w_beat_reg;
    logic [7:0]        w_beat_data;
    logic [ADDR_W-1:0] w_beat_i_data;

    logic [ADDR_W-1:0] w_addr, w_i_next;
    logic [3:0]        w_hund, w_tens, w_ones, w_digit;
    logic              w_last_idx;

    bin2bcd8 u_bcd (
        .bin      (r_vx),
        .hundreds (w_hund),
        .tens     (w_tens),
        .ones     (w_ones)
    );

    assign w_addr     = r_i + ADDR_W'(r_idx);
    assign w_i_next   = r_i + ADDR_W'(r_x) + ADDR_W'(1);
    assign w_last_idx = (r_idx == r_x);
    assign w_digit    = (r_idx == 4'd0) ? w_hund :
                        (r_idx == 4'd1) ? w_tens : w_ones;

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_beat_load   = 1'b0;
        w_beat_reg    = 4'd0;
        w_beat_data   = 8'd0;
        w_beat_we     = 1'b0;
        w_beat_i_we   = 1'b0;
        w_beat_i_data = '0;
        w_beat_last   = 1'b0;
        in_ready      = 1'b0;
        rf_raddr      = 4'd0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = 8'd0;
        mem_re        = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_idx_nxt = 4'd0;
                    case (mem_op_e'(in_op))
                        OP_PASS: begin
                            w_state_nxt = S_OUT;
                            w_beat_load = 1'b1;
                            w_beat_reg  = in_dst;
                            w_beat_data = in_data;
                            w_beat_we   = in_we;
                            w_beat_last = 1'b1;
                        end
                        OP_STORE_REGS: w_state_nxt = S_STORE;
                        OP_LOAD_REGS:  w_state_nxt = S_LD_RD;
                        default:       w_state_nxt = S_BCD;
                    endcase
                end
            end
            S_OUT: begin
                if (wb_ready) w_state_nxt = S_IDLE;
            end
            S_STORE: begin
                rf_raddr  = r_idx;
                mem_we    = 1'b1;
                mem_addr  = w_addr;
                mem_wdata = rf_rdata;
                if (w_last_idx) begin
                    w_state_nxt   = S_OUT;
                    w_beat_load   = 1'b1;
                    w_beat_i_we   = c_inc_i;
                    w_beat_i_data = w_i_next;
                    w_beat_last   = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            S_LD_RD: begin
                // Beat metadata is registered now; its data arrives next cycle.
                mem_re        = 1'b1;
                mem_addr      = w_addr;
                w_state_nxt   = S_LD_WB;
                w_beat_load   = 1'b1;
                w_beat_reg    = r_idx;
                w_beat_we     = 1'b1;
                w_beat_last   = w_last_idx;
                w_beat_i_we   = w_last_idx & c_inc_i;
                w_beat_i_data = w_last_idx ? w_i_next : '0;
            end
            S_LD_WB: begin
                if (wb_ready) begin
                    if (r_wb_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = S_LD_RD;
                    end
                end
            end
            S_BCD: begin
                mem_we    = 1'b1;
                mem_addr  = w_addr;
                mem_wdata = {4'd0, w_digit};
                if (r_idx == 4'd2) begin
                    w_state_nxt = S_OUT;
                    w_beat_load = 1'b1;
                    w_beat_last = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_x         <= 4'd0;
            r_i         <= '0;
            r_vx        <= 8'd0;
            r_ld_first  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_reg    <= 4'd0;
            r_wb_data   <= 8'd0;
            r_wb_we     <= 1'b0;
            r_wb_i_we   <= 1'b0;
            r_wb_i_data <= '0;
            r_wb_last   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_ld_first <= (r_state == S_LD_RD);
            if (r_state == S_IDLE && in_valid) begin
                r_x  <= in_x;
                r_i  <= in_i;
                r_vx <= in_vx;
            end
            if (w_beat_load) begin
                r_wb_valid  <= 1'b1;
                r_wb_reg    <= w_beat_reg;
                r_wb_data   <= w_beat_data;
                r_wb_we     <= w_beat_we;
                r_wb_i_we   <= w_beat_i_we;
                r_wb_i_data <= w_beat_i_data;
                r_wb_last   <= w_beat_last;
            end else if (r_wb_valid && wb_ready) begin
                r_wb_valid  <= 1'b0;
                r_wb_reg    <= 4'd0;
                r_wb_data   <= 8'd0;
                r_wb_we     <= 1'b0;
                r_wb_i_we   <= 1'b0;
                r_wb_i_data <= '0;
                r_wb_last   <= 1'b0;
            end else if (r_ld_first) begin
                // Stalled load beat: hold the read data, the memory may not.
                r_wb_data <= mem_rdata;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_reg    = r_wb_reg;
    assign wb_data   = r_ld_first ? mem_rdata : r_wb_data;
    assign wb_we     = r_wb_we;
    assign wb_i_we   = r_wb_i_we;
    assign wb_i_data = r_wb_i_data;
    assign wb_last   = r_wb_last;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Two instances share stimulus:
//            u_dut (INC_I=1) drives the memory model, u_dut0 (INC_I=0) reads
//            the same memory and is compared for the I-update difference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import chip8_pkg::*;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_we, wb_ready;
    logic [1:0]    in_op;
    logic [3:0]    in_x, in_dst;
    logic [AW-1:0] in_i;
    logic [7:0]    in_vx, in_data;

    logic          in_ready, mem_we, mem_re, wb_valid, wb_we, wb_i_we, wb_last;
    logic [3:0]    rf_raddr, wb_reg;
    logic [7:0]    rf_rdata, mem_wdata, mem_rdata, wb_data;
    logic [AW-1:0] mem_addr, wb_i_data;

    logic          in_ready_z, mem_we_z, mem_re_z, wb_valid_z, wb_we_z, wb_i_we_z, wb_last_z;
    logic [3:0]    rf_raddr_z, wb_reg_z;
    logic [7:0]    rf_rdata_z, mem_wdata_z, mem_rdata_z, wb_data_z;
    logic [AW-1:0] mem_addr_z, wb_i_data_z;

    logic [7:0]    rf [16];
    logic [7:0]    mem [4096];
    logic [AW-1:0] wa [256];
    logic [7:0]    wd [256];
    int            wc [256];
    int            cyc = 0, n_wr = 0, n_reads = 0, viol = 0;
    int            n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    assign rf_rdata   = rf[rf_raddr];
    assign rf_rdata_z = rf[rf_raddr_z];

    mem_stage #(.ADDR_W(AW), .INC_I(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_x(in_x), .in_i(in_i), .in_vx(in_vx),
        .in_dst(in_dst), .in_data(in_data), .in_we(in_we),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
        .wb_data(wb_data), .wb_we(wb_we), .wb_i_we(wb_i_we),
        .wb_i_data(wb_i_data), .wb_last(wb_last)
    );

    mem_stage #(.ADDR_W(AW), .INC_I(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_op(in_op), .in_x(in_x), .in_i(in_i), .in_vx(in_vx),
        .in_dst(in_dst), .in_data(in_data), .in_we(in_we),
        .rf_raddr(rf_raddr_z), .rf_rdata(rf_rdata_z),
        .mem_addr(mem_addr_z), .mem_we(mem_we_z), .mem_wdata(mem_wdata_z),
        .mem_re(mem_re_z), .mem_rdata(mem_rdata_z),
        .wb_valid(wb_valid_z), .wb_ready(wb_ready), .wb_reg(wb_reg_z),
        .wb_data(wb_data_z), .wb_we(wb_we_z), .wb_i_we(wb_i_we_z),
        .wb_i_data(wb_i_data_z), .wb_last(wb_last_z)
    );

    // Synchronous memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr]   <= mem_wdata;
            wa[n_wr & 255]  <= mem_addr;
            wd[n_wr & 255]  <= mem_wdata;
            wc[n_wr & 255]  <= cyc;
            n_wr            <= n_wr + 1;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            n_reads   <= n_reads + 1;
        end
        if (mem_re_z) mem_rdata_z <= mem[mem_addr_z];
    end

    // Strobe legality: never both, never while idle or presenting a beat.
    always @(negedge clk) begin
        if (!rst) begin
            if ((mem_we && mem_re) || ((wb_valid || in_ready) && (mem_we || mem_re)))
                viol <= viol + 1;
            if ((mem_we_z && mem_re_z) || ((wb_valid_z || in_ready_z) && (mem_we_z || mem_re_z)))
                viol <= viol + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] x, input logic [AW-1:0] i,
                         input logic [7:0] vx, input logic [3:0] dst, input logic [7:0] data,
                         input logic we);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_op = op; in_x = x; in_i = i; in_vx = vx;
        in_dst = dst; in_data = data; in_we = we;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accept edge until a beat is visible, bounded.
    task automatic wait_beat(output int e);
        e = 0;
        while (!wb_valid && e < 40) begin
            @(posedge clk); #1;
            e++;
        end
    endtask

    task automatic do_store(input logic [3:0] x, input logic [AW-1:0] i);
        int e, base;
        logic [AW-1:0] a, inext;
        base = n_wr;
        issue(OP_STORE_REGS, x, i, 8'd0, 4'd0, 8'd0, 1'b0);
        wait_beat(e);
        chk("store_latency", e, int'(x) + 1);
        chk("store_nwrites", n_wr - base, int'(x) + 1);
        for (int k = 0; k <= int'(x); k++) begin
            a = i + AW'(k);
            chk("store_addr", {20'd0, wa[(base + k) & 255]}, {20'd0, a});
            chk("store_data", {24'd0, wd[(base + k) & 255]}, {24'd0, rf[k]});
            chk("store_consecutive", wc[(base + k) & 255] - wc[base & 255], k);
        end
        inext = i + AW'(x) + AW'(1);
        chk("store_wb_we", {31'd0, wb_we}, 32'd0);
        chk("store_wb_last", {31'd0, wb_last}, 32'd1);
        chk("store_wb_i_we", {31'd0, wb_i_we}, 32'd1);
        chk("store_wb_i_data", {20'd0, wb_i_data}, {20'd0, inext});
        chk("store_noinc_i_we", {31'd0, wb_i_we_z}, 32'd0);
        chk("store_in_ready_busy", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("store_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("store_valid_after", {31'd0, wb_valid}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [AW-1:0]   i;
        logic [7:0]      vx;
        logic [3:0]      dst;
        logic [7:0]      data;
        logic            we;
        int              lat;
        int              nw;
        logic [2:0][7:0] dig;
    } vec_t;

    vec_t tv [7];

    initial begin
        int e, base, r0, t;
        logic [AW-1:0] a;

        rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_x = 4'd0; in_i = '0;
        in_vx = 8'd0; in_dst = 4'd0; in_data = 8'd0; in_we = 1'b0; wb_ready = 1'b1;
        for (int k = 0; k < 16; k++) rf[k] = 8'(8'h10 * k);
        rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33;

        //        op        i        vx     dst   data   we  lat nw  {ones,tens,hund}
        tv[0] = '{OP_PASS, 12'h000, 8'h00, 4'd3,  8'h5A, 1'b1, 0, 0, {8'd0, 8'd0, 8'd0}};
        tv[1] = '{OP_PASS, 12'h000, 8'h00, 4'd15, 8'h00, 1'b0, 0, 0, {8'd0, 8'd0, 8'd0}};
        tv[2] = '{OP_PASS, 12'h000, 8'h00, 4'd0,  8'hFF, 1'b1, 0, 0, {8'd0, 8'd0, 8'd0}};
        tv[3] = '{OP_BCD,  12'h200, 8'hFE, 4'd0,  8'h00, 1'b0, 3, 3, {8'd4, 8'd5, 8'd2}};
        tv[4] = '{OP_BCD,  12'h100, 8'h00, 4'd0,  8'h00, 1'b0, 3, 3, {8'd0, 8'd0, 8'd0}};
        tv[5] = '{OP_BCD,  12'hFFE, 8'hFF, 4'd0,  8'h00, 1'b0, 3, 3, {8'd5, 8'd5, 8'd2}};
        tv[6] = '{OP_BCD,  12'h010, 8'h09, 4'd0,  8'h00, 1'b0, 3, 3, {8'd9, 8'd0, 8'd0}};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("reset_wb_fields", {wb_reg, wb_data, wb_we, wb_i_we, wb_last, wb_i_data},
            32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-beat instructions from the table.
        for (int v = 0; v < 7; v++) begin
            base = n_wr;
            issue(tv[v].op, 4'd0, tv[v].i, tv[v].vx, tv[v].dst, tv[v].data, tv[v].we);
            wait_beat(e);
            chk("vec_latency", e, tv[v].lat);
            chk("vec_last", {31'd0, wb_last}, 32'd1);
            chk("vec_i_we", {31'd0, wb_i_we}, 32'd0);
            chk("vec_we", {31'd0, wb_we}, {31'd0, tv[v].we});
            if (tv[v].op == OP_PASS) begin
                chk("vec_reg", {28'd0, wb_reg}, {28'd0, tv[v].dst});
                chk("vec_data", {24'd0, wb_data}, {24'd0, tv[v].data});
            end
            chk("vec_in_ready_busy", {31'd0, in_ready}, 32'd0);
            chk("vec_nwrites", n_wr - base, tv[v].nw);
            for (int k = 0; k < tv[v].nw; k++) begin
                a = tv[v].i + AW'(k);
                chk("vec_waddr", {20'd0, wa[(base + k) & 255]}, {20'd0, a});
                chk("vec_wdata", {24'd0, wd[(base + k) & 255]}, {24'd0, tv[v].dig[k]});
            end
            @(posedge clk); #1;
            chk("vec_in_ready_after", {31'd0, in_ready}, 32'd1);
            chk("vec_valid_after", {31'd0, wb_valid}, 32'd0);
        end

        // STORE x=2 at 0x300, then STORE x=1 across the address wrap.
        do_store(4'd2, 12'h300);
        rf[0] = 8'hAB; rf[1] = 8'hCD;
        do_store(4'd1, 12'hFFF);

        // LOAD x=1 from 0xFFF with a 3-cycle stall on the first beat.
        wb_ready = 1'b0;
        r0 = n_reads;
        issue(OP_LOAD_REGS, 4'd1, 12'hFFF, 8'd0, 4'd0, 8'd0, 1'b0);
        wait_beat(e);
        chk("load_latency0", e, 1);
        chk("load_b0_reg", {28'd0, wb_reg}, 32'd0);
        chk("load_b0_data", {24'd0, wb_data}, 32'hAB);
        chk("load_b0_flags", {29'd0, wb_we, wb_i_we, wb_last}, 32'b100);
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("stall_beat", {wb_valid, wb_reg, wb_data, wb_last}, {1'b1, 4'd0, 8'hAB, 1'b0});
        end
        chk("stall_reads", n_reads - r0, 1);
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wait_beat(e);
        chk("load_latency1", e, 1);
        chk("load_b1_reg", {28'd0, wb_reg}, 32'd1);
        chk("load_b1_data", {24'd0, wb_data}, 32'hCD);
        chk("load_b1_flags", {29'd0, wb_we, wb_i_we, wb_last}, 32'b111);
        chk("load_b1_i_data", {20'd0, wb_i_data}, 32'h001);
        @(posedge clk); #1;
        chk("load_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("load_reads", n_reads - r0, 2);

        // LOAD x=0 from 0x300: INC_I=0 instance must not update I.
        issue(OP_LOAD_REGS, 4'd0, 12'h300, 8'd0, 4'd0, 8'd0, 1'b0);
        wait_beat(e);
        chk("load0_latency", e, 1);
        chk("noinc_valid", {31'd0, wb_valid_z}, 32'd1);
        chk("noinc_beat", {wb_reg_z, wb_data_z, wb_we_z, wb_i_we_z, wb_last_z},
            {4'd0, 8'h11, 1'b1, 1'b0, 1'b1});
        chk("inc_i_data", {19'd0, wb_i_we, wb_i_data}, {19'd0, 1'b1, 12'h301});
        @(posedge clk); #1;
        chk("load0_in_ready_after", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of STORE x=15 after four writes.
        issue(OP_STORE_REGS, 4'd15, 12'h400, 8'd0, 4'd0, 8'd0, 1'b0);
        base = n_wr - 0;
        t = 0;
        while ((n_wr - base) < 4 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("midrst_writes_before", n_wr - base, 4);
        chk("midrst_storing", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_addr", {20'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_no_more_writes", n_wr - base, 4);

        chk("strobe_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined CHIP-8 core. Sits between execute (upstream) and writeback (downstream).
- Forwards ALU results unchanged.
- Sequences the multi-cycle memory instructions: FX55 (store V0..VX), FX65 (load V0..VX) and FX33 (BCD store).
- Every accepted instruction retires as one or more beats to writeback. The final beat of each instruction has wb_last=1.

Parameters:
- ADDR_W, 12, memory address width; addresses wrap modulo 2^ADDR_W.
- INC_I, 1, if 1 then FX55/FX65 set I := I+X+1 (COSMAC quirk); if 0 then I is unchanged.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute has an instruction
- in_ready  out  1  stage can accept an instruction
- in_op  in  2  0=PASS, 1=STORE_REGS, 2=LOAD_REGS, 3=BCD
- in_x  in  4  X field
- in_i  in  ADDR_W  current I
- in_vx  in  8  value of VX (BCD source)
- in_dst  in  4  destination register (PASS)
- in_data  in  8  ALU result (PASS)
- in_we  in  1  register write enable (PASS)
- rf_raddr  out  4  register-file read index (STORE_REGS)
- rf_rdata  in  8  combinational register-file read data
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  8  memory write data
- mem_re  out  1  memory read strobe; data is valid on mem_rdata the following cycle
- mem_rdata  in  8  memory read data
- wb_valid  out  1  beat valid
- wb_ready  in  1  writeback accepts beat
- wb_reg  out  4  destination register
- wb_data  out  8  register write data
- wb_we  out  1  register write enable
- wb_i_we  out  1  write I
- wb_i_data  out  ADDR_W  new I
- wb_last  out  1  final beat of this instruction

Behaviour:
- Reset (asynchronous): state=IDLE, in_ready=1, all other outputs 0, internal counters 0.
- Handshake:
  - A transfer occurs on valid&&ready.
  - wb_* outputs are registered. They hold stable while wb_valid&&!wb_ready.
  - in_ready=1 only in IDLE.
- States and transitions:
  - IDLE: on accept, latch op/x/i/vx/dst/data/we and set idx=0.
    - PASS goes to OUT.
    - STORE_REGS goes to STORE.
    - LOAD_REGS goes to LD_RD.
    - BCD goes to BCD.
  - OUT: drive wb_valid=1. On wb_ready go to IDLE.
    - PASS beat: wb_reg=dst, wb_data=data, wb_we=we, wb_last=1, wb_i_we=0.
  - STORE: each cycle drive rf_raddr=idx, mem_we=1, mem_addr=(i+idx) mod 2^ADDR_W, mem_wdata=rf_rdata, then idx++.
    - After the write with idx==x, go to OUT with a retire beat: wb_we=0, wb_i_we=INC_I, wb_i_data=i+x+1 (wrapped), wb_last=1.
  - LD_RD: drive mem_re=1, mem_addr=i+idx, then go to LD_WB.
  - LD_WB: latch mem_rdata on entry. Present the beat: wb_reg=idx, wb_we=1, wb_last=(idx==x), and on the last beat wb_i_we=INC_I with wb_i_data=i+x+1.
    - On wb_ready: if last go to IDLE, else idx++ and go to LD_RD.
  - BCD: three consecutive write cycles, no stall possible:
    - mem[i] = vx/100
    - mem[i+1] = (vx/10)%10
    - mem[i+2] = vx%10
    - Then go to OUT with a retire beat (wb_we=0, wb_i_we=0, wb_last=1).
- Latency, with accept in cycle N and wb_ready held high:
  - PASS: beat visible in N+1.
  - STORE X: writes in N+1..N+X+1, retire beat in N+X+2.
  - LOAD X: 2 cycles per register.
  - BCD: writes in N+1..N+3, retire beat in N+4.
- mem_we and mem_re are never both high. Neither is ever high in IDLE or OUT.
- Address wrap: I=0xFFF with offset 1 gives address 0x000. wb_i_data wraps the same way.
- Backpressure: wb_ready low stalls only OUT/LD_WB. Memory strobes are not re-issued during a stall.
- X=0: exactly one register transferred.
- Reset mid-operation: state aborts to IDLE. A partially completed store is not rolled back.

Decomposition:
- Package chip8_pkg: mem_op_e enum (PASS, STORE_REGS, LOAD_REGS, BCD), ADDR_W constant, and a wb_beat_t struct {reg, data, we, i_we, i_data, last} shared with writeback.
- Sub-module bin2bcd8: combinational 8-bit to {hundreds, tens, ones}, each 4-bit, via double-dabble. Instantiated once.

Test Plan:
- PASS dst=3, data=0x5A, we=1, wb_ready=1 -> one beat next cycle: reg=3, data=0x5A, we=1, last=1; in_ready returns the cycle after.
- STORE_REGS x=2, i=0x300, V0..V2=0x11,0x22,0x33 -> mem writes 0x300=0x11, 0x301=0x22, 0x302=0x33 in consecutive cycles; retire beat i_we=1, i_data=0x303 (INC_I=1).
- LOAD_REGS x=1, i=0xFFF, mem[0xFFF]=0xAB, mem[0x000]=0xCD, with wb_ready low for 3 cycles on the first beat -> beats (0,0xAB,last=0) then (1,0xCD,last=1,i_data=0x001); outputs stable during the stall; exactly 2 reads issued.
- BCD vx=0xFE (254) at i=0x200 -> mem[0x200]=2, mem[0x201]=5, mem[0x202]=4; retire beat wb_we=0, i_we=0.
- Reset asserted during STORE_REGS x=15 after 4 writes -> outputs zero immediately; in_ready=1 after release; no further writes.
- INC_I=0, LOAD_REGS x=0 -> single beat, last=1, i_we=0.
